lcd_win_stat: RTL and testbench
===============================

# lcd_win_stat

Downstream statistics stage for the LCD controller. It consumes the 9-pixel, row-major 3x3 window burst that the controller emits on `dataout`/`output_valid`, accumulates it and computes sum, max, min, centre pixel and floor mean. It presents one result record per window over a valid/ready handshake to the display/report logic.

## Interface
Parameters:
- `WIN_PIX`, 9: pixels per window burst.
- `PIX_W`, 8: pixel width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `pix_in` in 8: window pixel, driven by the LCD controller `dataout`.
- `pix_valid` in 1: pixel strobe, driven by the LCD controller `output_valid`.
- `res_ready` in 1: consumer accepts the result.
- `res_valid` out 1: result record valid.
- `res_sum` out 12: sum of the 9 pixels.
- `res_max` out 8: maximum pixel.
- `res_min` out 8: minimum pixel.
- `res_ctr` out 8: pixel index 4, the window centre.
- `res_mean` out 8: floor(sum/9).
- `frame_err` out 1: one-cycle pulse when a burst is aborted.
- `ovf` out 1: sticky flag; a completed result was lost. Cleared only by reset.

## Operation
- FSM states: IDLE, ACC, CALC.
- IDLE: `cnt` = 0.
  - `pix_valid` = 1: initialise acc_sum = pix, acc_max = pix, acc_min = pix; `cnt` becomes 1; go to ACC.
- ACC:
  - `pix_valid` = 1: acc_sum += pix; max/min updated; if `cnt` == 4, latch ctr = pix; `cnt`++.
  - When `cnt` reaches 9, go to CALC.
  - `pix_valid` = 0 with 0 < `cnt` < 9: abort the burst, pulse `frame_err` for 1 cycle, go to IDLE. The accumulators are discarded.
- CALC, which lasts exactly one cycle:
  - Result register write: sum, max, min, ctr and mean = (acc_sum * 1821) >> 14. This uses a 23-bit product and is exact for 0..2295.
  - If `pix_valid` = 1 in CALC, that pixel starts the next burst: accumulators are initialised as in IDLE, `cnt` = 1, go to ACC. Otherwise go to IDLE.
- Result register:
  - It is separate from the accumulators. Accumulation of the next burst proceeds while a result is pending.
  - Write with `res_valid` = 0: the record is loaded and `res_valid` is set.
  - Write with `res_valid` = 1 and `res_ready` = 1 in the same cycle: the new record replaces the old one and `res_valid` stays 1. The old record is considered accepted.
  - Write with `res_valid` = 1 and `res_ready` = 0: the new record is discarded, the old one is held and `ovf` is set.
  - `res_valid` clears on `res_valid && res_ready` when no write occurs that cycle.
- Arithmetic: sum is 12-bit unsigned, max 2295. All compares are unsigned.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, accumulators 0.
- Reset mid-burst: the burst is discarded. The first `pix_valid` after release is treated as pixel 0.
- Latency: edge E samples pixel 9. Edge E+1 (CALC) writes the result, so `res_valid` is high after E+1, two edges after the pixel-9 sampling edge.
- Throughput: back-to-back bursts with zero gap are supported. This covers the CALC-overlap case.
- `frame_err` rises at the edge that samples the gap and lasts exactly 1 cycle.
- Outputs are stable while `res_valid` = 1 and `res_ready` = 0.

## Structure
- Shared package `lcd_pkg`:
  - FSM state enum (IDLE/ACC/CALC).
  - `LCD_WIN_PIX` = 9.
  - `LCD_PIX_W` = 8.
  - `LCD_MEAN_MUL` = 1821.
  - `LCD_MEAN_SH` = 14.
  - The upstream command codes also live in this package.
- One sub-module, `lcd_div9`: combinational 12-bit to 8-bit constant-multiply divider. It is instantiated in CALC and unit-testable exhaustively over 0..2295.

## Test plan
- Pixels 10,20,…,90 contiguous, `res_ready` = 1 -> sum 450, max 90, min 10, ctr 50, mean 50. `res_valid` high two edges after pixel 9.
- Nine 255s -> sum 2295, mean 255. Pixels 0,0,0,0,0,0,0,0,8 -> sum 8, mean 0, min 0, ctr 0.
- Burst broken after 4 pixels, then a full burst of 9x 7 -> one `frame_err` pulse at the gap. Only a single result is produced: sum 63, mean 7.
- Two back-to-back bursts with zero gap, `res_ready` = 1 -> two records, the second written 9 cycles after the first. No error.
- `res_ready` = 0 while two bursts complete -> first record held unchanged, `ovf` = 1. Raising `res_ready` then drops `res_valid` next cycle.
- Assert `reset` after 5 pixels -> all outputs 0 immediately. The next 9-pixel burst of 1s yields sum 9, mean 1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD controller and its window statistics stage.
package lcd_pkg;
  localparam int LCD_WIN_PIX  = 9;
  localparam int LCD_PIX_W    = 8;
  localparam int LCD_MEAN_MUL = 1821;
  localparam int LCD_MEAN_SH  = 14;
  typedef enum logic [1:0] {IDLE, ACC, CALC} lcd_state_e;
  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5
  } lcd_cmd_e;
endpackage

// File: rtl/lcd_div9.sv
// lcd_div9: floor(x/9) for x in 0..2295 via multiply by 1821 and shift by 14.
module lcd_div9
  import lcd_pkg::*;
(
  input  logic [11:0] i_sum,
  output logic [7:0]  o_mean
);
  logic [22:0] w_prod;
  assign w_prod = {11'd0, i_sum} * 23'(LCD_MEAN_MUL);
  assign o_mean = 8'(w_prod >> LCD_MEAN_SH);
endmodule

// File: rtl/lcd_win_stat.sv
// lcd_win_stat: accumulates a 3x3 pixel burst and publishes sum/max/min/centre/mean
// over valid/ready, with abort detection and a sticky lost-result flag.
module lcd_win_stat
  import lcd_pkg::*;
#(
  parameter int WIN_PIX = LCD_WIN_PIX,
  parameter int PIX_W   = LCD_PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [11:0]      res_sum,
  output logic [7:0]       res_max,
  output logic [7:0]       res_min,
  output logic [7:0]       res_ctr,
  output logic [7:0]       res_mean,
  output logic             frame_err,
  output logic             ovf
);
  localparam int CW = $clog2(WIN_PIX + 1);
  localparam logic [CW-1:0] LAST = CW'(WIN_PIX - 1);
  localparam logic [CW-1:0] CTR  = CW'(WIN_PIX / 2);
  lcd_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [11:0]      r_acc_sum;
  logic [PIX_W-1:0] r_acc_max, r_acc_min, r_acc_ctr;
  logic [11:0]      w_pix;
  logic [7:0]       w_mean;
  assign w_pix = 12'(pix_in);
  lcd_div9 u_div9 (.i_sum(r_acc_sum), .o_mean(w_mean));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc_sum <= '0;
      r_acc_max <= '0;
      r_acc_min <= '0;
      r_acc_ctr <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_max   <= '0;
      res_min   <= '0;
      res_ctr   <= '0;
      res_mean  <= '0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // a pending unaccepted record wins over a new one; the loss is recorded in ovf
      if (r_state == CALC) begin
        if (!res_valid || res_ready) begin
          res_valid <= 1'b1;
          res_sum   <= r_acc_sum;
          res_max   <= 8'(r_acc_max);
          res_min   <= 8'(r_acc_min);
          res_ctr   <= 8'(r_acc_ctr);
          res_mean  <= w_mean;
        end else
          ovf <= 1'b1;
      end else if (res_valid && res_ready)
        res_valid <= 1'b0;
      case (r_state)
        IDLE, CALC:
          if (pix_valid) begin
            r_acc_sum <= w_pix;
            r_acc_max <= pix_in;
            r_acc_min <= pix_in;
            r_cnt     <= CW'(1);
            r_state   <= ACC;
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        ACC:
          if (pix_valid) begin
            r_acc_sum <= r_acc_sum + w_pix;
            r_acc_max <= (pix_in > r_acc_max) ? pix_in : r_acc_max;
            r_acc_min <= (pix_in < r_acc_min) ? pix_in : r_acc_min;
            if (r_cnt == CTR) r_acc_ctr <= pix_in;
            r_cnt   <= r_cnt + CW'(1);
            r_state <= (r_cnt == LAST) ? CALC : ACC;
          end else begin
            frame_err <= 1'b1;
            r_cnt     <= '0;
            r_state   <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lcd_win_stat.sv
// tb_lcd_win_stat: directed vectors with hand-computed window statistics.
module tb_lcd_win_stat;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        res_ready = 1'b1;
  logic        res_valid, frame_err, ovf;
  logic [11:0] res_sum;
  logic [7:0]  res_max, res_min, res_ctr, res_mean;
  int n_vec = 0;
  int n_err = 0;
  lcd_win_stat dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .res_ready(res_ready), .res_valid(res_valid), .res_sum(res_sum),
    .res_max(res_max), .res_min(res_min), .res_ctr(res_ctr),
    .res_mean(res_mean), .frame_err(frame_err), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] p);
    pix_valid = 1'b1;
    pix_in = p;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_rec(input string tag, input logic [11:0] s, input logic [7:0] mx,
                         input logic [7:0] mn, input logic [7:0] c, input logic [7:0] m);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_sum"}, 32'(res_sum), 32'(s));
    chk({tag, "_max"}, 32'(res_max), 32'(mx));
    chk({tag, "_min"}, 32'(res_min), 32'(mn));
    chk({tag, "_ctr"}, 32'(res_ctr), 32'(c));
    chk({tag, "_mean"}, 32'(res_mean), 32'(m));
  endtask
  initial begin
    #12;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_sum", 32'(res_sum), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i * 10));
    pix_valid = 1'b0;
    chk("ramp_latency", 32'(res_valid), 32'd0);
    idle(1);
    chk_rec("ramp", 12'd450, 8'd90, 8'd10, 8'd50, 8'd50);
    idle(1);
    chk("ramp_drain", 32'(res_valid), 32'd0);
    repeat (9) push(8'd255);
    idle(1);
    chk_rec("full", 12'd2295, 8'd255, 8'd255, 8'd255, 8'd255);
    idle(1);
    for (int i = 0; i < 9; i++) push((i == 8) ? 8'd8 : 8'd0);
    idle(1);
    chk_rec("zero", 12'd8, 8'd8, 8'd0, 8'd0, 8'd0);
    idle(1);
    repeat (4) push(8'd3);
    idle(1);
    chk("abort_err", 32'(frame_err), 32'd1);
    chk("abort_noresult", 32'(res_valid), 32'd0);
    idle(1);
    chk("abort_pulse", 32'(frame_err), 32'd0);
    repeat (9) push(8'd7);
    chk("abort_pending", 32'(res_valid), 32'd0);
    idle(1);
    chk_rec("after_abort", 12'd63, 8'd7, 8'd7, 8'd7, 8'd7);
    idle(1);
    for (int i = 0; i < 18; i++) begin
      push((i < 9) ? 8'd1 : 8'd2);
      if (i == 9) chk_rec("b2b_first", 12'd9, 8'd1, 8'd1, 8'd1, 8'd1);
      if (i == 10) chk("b2b_gap", 32'(res_valid), 32'd0);
      if (i == 16) chk("b2b_early", 32'(res_valid), 32'd0);
      chk("b2b_noerr", 32'(frame_err), 32'd0);
    end
    idle(1);
    chk_rec("b2b_second", 12'd18, 8'd2, 8'd2, 8'd2, 8'd2);
    idle(1);
    res_ready = 1'b0;
    repeat (9) push(8'd4);
    idle(1);
    chk_rec("hold_a", 12'd36, 8'd4, 8'd4, 8'd4, 8'd4);
    chk("hold_noovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 9; i++) push(8'(i + 1));
    idle(1);
    chk_rec("hold_kept", 12'd36, 8'd4, 8'd4, 8'd4, 8'd4);
    chk("hold_ovf", 32'(ovf), 32'd1);
    res_ready = 1'b1;
    idle(1);
    chk("hold_drop", 32'(res_valid), 32'd0);
    chk("hold_sticky", 32'(ovf), 32'd1);
    repeat (5) push(8'd9);
    pix_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_sum", 32'(res_sum), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (9) push(8'd1);
    idle(1);
    chk_rec("post_rst", 12'd9, 8'd1, 8'd1, 8'd1, 8'd1);
    chk("post_rst_err", 32'(frame_err), 32'd0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
